// File: rtl/rat_intr_ctrl_if.sv
// MCU port-I/O bus seen by the interrupt controller: write strobe/data from
// the MCU and combinational read data back into the MCU input mux.
interface rat_intr_ctrl_if;
   logic [7:0] port_id;
   logic [7:0] out_port;
   logic       io_strb;
   logic [7:0] rd_data;
   logic       rd_hit;

   modport master (
      output port_id,
      output out_port,
      output io_strb,
      input  rd_data,
      input  rd_hit
   );

   modport slave (
      input  port_id,
      input  out_port,
      input  io_strb,
      output rd_data,
      output rd_hit
   );
endinterface

// File: rtl/rat_intr_ctrl.sv
// Eight-source edge-triggered interrupt controller for a small MCU: mask,
// pending status, write-1-to-clear acknowledge and a fixed-width INTR pulse.
module rat_intr_ctrl #(
   parameter logic [7:0]  MASK_ID    = 8'h20,
   parameter logic [7:0]  STATUS_ID  = 8'h21,
   parameter logic [7:0]  ACK_ID     = 8'h22,
   parameter int unsigned INTR_PULSE = 2
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic [7:0]        irq_in_i,
   rat_intr_ctrl_if.slave    bus,
   output logic              intr_o
);

   typedef enum logic [1:0] {IDLE, ASSERT, WAIT_ACK} state_e;

   localparam logic [3:0] PULSE_LOAD = 4'(INTR_PULSE);

   logic [7:0] sync1_q, sync2_q, prev_q;
   logic [7:0] mask_q, mask_d;
   logic [7:0] pend_q, pend_d;
   logic [7:0] rise;
   logic [3:0] cnt_q, cnt_d;
   state_e     state_q, state_d;
   logic       intr_q, intr_d;
   logic       mask_wr, ack_wr;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         sync1_q <= 8'h00;
         sync2_q <= 8'h00;
         prev_q  <= 8'h00;
      end else begin
         sync1_q <= irq_in_i;
         sync2_q <= sync1_q;
         prev_q  <= sync2_q;
      end
   end

   assign rise    = sync2_q & ~prev_q;
   assign mask_wr = bus.io_strb && (bus.port_id == MASK_ID);
   assign ack_wr  = bus.io_strb && (bus.port_id == ACK_ID);
   assign mask_d  = mask_wr ? bus.out_port : mask_q;

   // A new edge outranks a simultaneous acknowledge of the same bit.
   generate
      for (genvar gi = 0; gi < 8; gi++) begin : g_pend
         assign pend_d[gi] = rise[gi] | (pend_q[gi] & ~(ack_wr & bus.out_port[gi]));
      end
   endgenerate

   always_comb begin
      bus.rd_hit  = (bus.port_id == MASK_ID) || (bus.port_id == STATUS_ID);
      bus.rd_data = 8'h00;
      if (bus.port_id == MASK_ID)
         bus.rd_data = mask_q;
      else if (bus.port_id == STATUS_ID)
         bus.rd_data = pend_q;
   end

   // Only IDLE looks at pending/mask, so mask edits or new edges during a
   // pulse sequence wait until the acknowledge brings the FSM back.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            if ((pend_q & mask_q) != 8'h00) begin
               state_d = ASSERT;
               cnt_d   = PULSE_LOAD;
            end
         end
         ASSERT: begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_q <= 4'd1)
               state_d = WAIT_ACK;
         end
         WAIT_ACK: begin
            if (ack_wr)
               state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      intr_d = (state_d == ASSERT);
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         mask_q  <= 8'h00;
         pend_q  <= 8'h00;
         cnt_q   <= 4'd0;
         state_q <= IDLE;
         intr_q  <= 1'b0;
      end else begin
         mask_q  <= mask_d;
         pend_q  <= pend_d;
         cnt_q   <= cnt_d;
         state_q <= state_d;
         intr_q  <= intr_d;
      end
   end

   assign intr_o = intr_q;

endmodule

// File: tb/tb_rat_intr_ctrl.sv
// Bench for rat_intr_ctrl: register-access table, directed pulse/ack/reset
// sequences and a randomized run against a cycle-level reference model.
module tb_rat_intr_ctrl;

   localparam logic [7:0] MASK_ID   = 8'h20;
   localparam logic [7:0] STATUS_ID = 8'h21;
   localparam logic [7:0] ACK_ID    = 8'h22;
   localparam int         PULSE     = 2;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] irq;
   logic       intr;

   rat_intr_ctrl_if bus_if();

   rat_intr_ctrl #(
      .MASK_ID(MASK_ID), .STATUS_ID(STATUS_ID), .ACK_ID(ACK_ID), .INTR_PULSE(PULSE)
   ) dut (
      .clk_i(clk), .rst_i(rst), .irq_in_i(irq), .bus(bus_if), .intr_o(intr)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct {
      logic [7:0] port;
      logic       strb;
      logic [7:0] data;
      logic       exp_hit;
      logic [7:0] exp_rd;
   } vec_t;

   vec_t vecs [10];

   // Reference model: raw input samples per edge, pending/mask, and the
   // interrupt sequence as "pulse cycles left" plus an awaiting-ack flag.
   logic [7:0] m_hist [3];
   logic [7:0] m_mask, m_pend;
   int         m_pulse_rem;
   bit         m_waiting;

   task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic check1(input string name, input logic act, input logic exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b, expected %b at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic bus_idle();
      bus_if.port_id  = 8'h00;
      bus_if.out_port = 8'h00;
      bus_if.io_strb  = 1'b0;
   endtask

   task automatic write_reg(input logic [7:0] id, input logic [7:0] data);
      bus_if.port_id  = id;
      bus_if.out_port = data;
      bus_if.io_strb  = 1'b1;
      tick();
      bus_idle();
   endtask

   task automatic check_reg(input string name, input logic [7:0] id, input logic [7:0] exp);
      bus_if.io_strb = 1'b0;
      bus_if.port_id = id;
      #1;
      check8(name, bus_if.rd_data, exp);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      irq = 8'h00;
      bus_idle();
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   task automatic model_reset();
      for (int i = 0; i < 3; i++) m_hist[i] = 8'h00;
      m_mask      = 8'h00;
      m_pend      = 8'h00;
      m_pulse_rem = 0;
      m_waiting   = 1'b0;
   endtask

   task automatic model_edge(input logic [7:0] x, input logic [7:0] port,
                             input logic strb, input logic [7:0] data);
      logic [7:0] rise;
      logic       ack;
      rise = m_hist[1] & ~m_hist[2];
      ack  = strb && (port == ACK_ID);
      if (m_waiting) begin
         if (ack) m_waiting = 1'b0;
      end else if (m_pulse_rem > 0) begin
         m_pulse_rem--;
         if (m_pulse_rem == 0) m_waiting = 1'b1;
      end else if ((m_pend & m_mask) != 8'h00) begin
         m_pulse_rem = PULSE;
      end
      m_pend = (m_pend & ~(ack ? data : 8'h00)) | rise;
      if (strb && port == MASK_ID) m_mask = data;
      m_hist[2] = m_hist[1];
      m_hist[1] = m_hist[0];
      m_hist[0] = x;
   endtask

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0] = '{8'h20, 1'b1, 8'hA5, 1'b1, 8'h00};
      vecs[1] = '{8'h20, 1'b0, 8'h00, 1'b1, 8'hA5};
      vecs[2] = '{8'h21, 1'b0, 8'h00, 1'b1, 8'h00};
      vecs[3] = '{8'h22, 1'b0, 8'h00, 1'b0, 8'h00};
      vecs[4] = '{8'hFF, 1'b0, 8'h00, 1'b0, 8'h00};
      vecs[5] = '{8'h20, 1'b1, 8'h3C, 1'b1, 8'hA5};
      vecs[6] = '{8'h20, 1'b0, 8'h00, 1'b1, 8'h3C};
      vecs[7] = '{8'h10, 1'b0, 8'h00, 1'b0, 8'h00};
      vecs[8] = '{8'h20, 1'b1, 8'h00, 1'b1, 8'h3C};
      vecs[9] = '{8'h20, 1'b0, 8'h00, 1'b1, 8'h00};

      // Reset state
      do_reset();
      check1("reset intr", intr, 1'b0);
      check_reg("reset mask", MASK_ID, 8'h00);
      check_reg("reset status", STATUS_ID, 8'h00);

      // Register access table
      for (int i = 0; i < 10; i++) begin
         bus_if.port_id  = vecs[i].port;
         bus_if.io_strb  = vecs[i].strb;
         bus_if.out_port = vecs[i].data;
         #1;
         check1("table rd_hit", bus_if.rd_hit, vecs[i].exp_hit);
         check8("table rd_data", bus_if.rd_data, vecs[i].exp_rd);
         $display("[TB] vec %0d port=%h strb=%b data=%h rd_hit=%b rd_data=%h",
                  i, vecs[i].port, vecs[i].strb, vecs[i].data, bus_if.rd_hit, bus_if.rd_data);
         tick();
         check1("table intr", intr, 1'b0);
      end
      bus_idle();

      // Basic pulse, then acknowledge in WAIT_ACK
      do_reset();
      write_reg(MASK_ID, 8'h01);
      irq[0] = 1'b1;
      tick(); check_reg("A pend k", STATUS_ID, 8'h00);
      tick(); check_reg("A pend k+1", STATUS_ID, 8'h00);
      tick(); check_reg("A pend k+2", STATUS_ID, 8'h01); check1("A intr k+2", intr, 1'b0);
      tick(); check1("A intr k+3", intr, 1'b1);
      tick(); check1("A intr k+4", intr, 1'b1);
      tick(); check1("A intr k+5", intr, 1'b0);
      tick(); check1("A intr k+6", intr, 1'b0);
      check_reg("A status", STATUS_ID, 8'h01);
      $display("[TB] seq A: single pulse on irq0 done");
      write_reg(ACK_ID, 8'h01);
      check_reg("B pend after ack", STATUS_ID, 8'h00);
      for (int i = 0; i < 4; i++) begin
         tick(); check1("B no intr", intr, 1'b0);
      end
      irq = 8'h00;
      $display("[TB] seq B: ack in WAIT_ACK done");

      // Masked source, later unmasked
      do_reset();
      irq[3] = 1'b1;
      repeat (3) tick();
      check_reg("C pend", STATUS_ID, 8'h08);
      for (int i = 0; i < 3; i++) begin
         tick(); check1("C masked intr", intr, 1'b0);
      end
      write_reg(MASK_ID, 8'h08);
      check1("C intr w", intr, 1'b0);
      tick(); check1("C intr w+1", intr, 1'b1);
      tick(); check1("C intr w+2", intr, 1'b1);
      tick(); check1("C intr w+3", intr, 1'b0);
      write_reg(ACK_ID, 8'h08);
      irq = 8'h00;
      $display("[TB] seq C: unmask pending irq3 done");

      // Edge and acknowledge of the same bit in one cycle
      do_reset();
      write_reg(MASK_ID, 8'h02);
      irq[1] = 1'b1;
      repeat (3) tick();
      tick(); check1("D intr k+3", intr, 1'b1);
      irq[1] = 1'b0;
      tick(); check1("D intr k+4", intr, 1'b1);
      tick(); check1("D intr k+5", intr, 1'b0);
      irq[1] = 1'b1;
      tick();
      tick();
      write_reg(ACK_ID, 8'h02);
      check_reg("D set wins", STATUS_ID, 8'h02);
      check1("D idle gap", intr, 1'b0);
      tick(); check1("D 2nd pulse a", intr, 1'b1);
      tick(); check1("D 2nd pulse b", intr, 1'b1);
      tick(); check1("D 2nd pulse end", intr, 1'b0);
      write_reg(ACK_ID, 8'h02);
      irq = 8'h00;
      $display("[TB] seq D: simultaneous set/ack done");

      // Reset in the middle of a pulse
      do_reset();
      write_reg(MASK_ID, 8'hFF);
      irq[2] = 1'b1;
      repeat (3) tick();
      tick(); check1("E intr before rst", intr, 1'b1);
      #2 rst = 1'b1;
      #1 check1("E async intr", intr, 1'b0);
      @(posedge clk);
      #1 rst = 1'b0;
      check_reg("E mask", MASK_ID, 8'h00);
      check_reg("E status", STATUS_ID, 8'h00);
      tick(); tick();
      check_reg("E status r+2", STATUS_ID, 8'h00);
      tick();
      check_reg("E status r+3", STATUS_ID, 8'h04);
      check1("E masked intr", intr, 1'b0);
      write_reg(ACK_ID, 8'h04);
      repeat (4) tick();
      check_reg("E single edge", STATUS_ID, 8'h00);
      irq = 8'h00;
      $display("[TB] seq E: reset mid-pulse done");

      // Randomized run against the reference model
      do_reset();
      model_reset();
      for (int cyc = 0; cyc < 600; cyc++) begin
         logic [7:0] port, data, exp_rd;
         logic       strb;
         int         r;
         for (int b = 0; b < 8; b++)
            if ($urandom_range(0, 9) == 0) irq[b] = ~irq[b];
         r    = int'($urandom_range(0, 99));
         strb = 1'b0;
         data = 8'h00;
         if (r < 8) begin
            strb = 1'b1; port = MASK_ID; data = 8'($urandom);
         end else if (r < 22) begin
            strb = 1'b1; port = ACK_ID;
            case ($urandom_range(0, 3))
               0:       data = 8'h00;
               1, 2:    data = m_pend;
               default: data = 8'($urandom);
            endcase
         end else begin
            case ($urandom_range(0, 4))
               0:       port = MASK_ID;
               1, 2:    port = STATUS_ID;
               3:       port = 8'hFF;
               default: port = 8'($urandom);
            endcase
            if ($urandom_range(0, 7) == 0) begin
               strb = 1'b1; data = 8'($urandom);
            end
         end
         bus_if.port_id  = port;
         bus_if.out_port = data;
         bus_if.io_strb  = strb;
         #1;
         exp_rd = (port == MASK_ID) ? m_mask : (port == STATUS_ID) ? m_pend : 8'h00;
         check1("rand rd_hit", bus_if.rd_hit, (port == MASK_ID) || (port == STATUS_ID));
         check8("rand rd_data", bus_if.rd_data, exp_rd);
         @(posedge clk);
         model_edge(irq, port, strb, data);
         #1;
         check1("rand intr", intr, (m_pulse_rem > 0));
         if (strb && (port == MASK_ID || port == ACK_ID))
            $display("[TB] rand cyc %0d write port=%h data=%h -> pend=%h mask=%h intr=%b",
                     cyc, port, data, m_pend, m_mask, intr);
      end
      bus_idle();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/rat_intr_ctrl.md
RAT_INTR_CTRL -- requirements
Module: rat_intr_ctrl

Interface
REQ-001 Parameter MASK_ID, default 8'h20, port ID of the read/write interrupt-enable mask register.
REQ-002 Parameter STATUS_ID, default 8'h21, port ID of the read-only pending-status register.
REQ-003 Parameter ACK_ID, default 8'h22, port ID of the write-1-to-clear acknowledge register.
REQ-004 Parameter INTR_PULSE, default 2, CLK cycles INTR is held high per request (range 1-15); the default covers the MCU's CLK/2 core clock.
REQ-005 CLK  input  1  system clock; all state updates on the rising edge.
REQ-006 RESET  input  1  asynchronous, active-high reset.
REQ-007 IRQ_IN  input  8  asynchronous interrupt source lines, one per bit, rising-edge sensitive.
REQ-008 PORT_ID  input  8  MCU port ID.
REQ-009 OUT_PORT  input  8  MCU output data.
REQ-010 IO_STRB  input  1  MCU output strobe; one write is accepted per CLK cycle with IO_STRB high.
REQ-011 RD_DATA  output  8  combinational read data for the wrapper input mux.
REQ-012 RD_HIT  output  1  combinational; high when PORT_ID equals MASK_ID or STATUS_ID.
REQ-013 INTR  output  1  registered interrupt request to the MCU INTR pin.

Function
REQ-014 Each IRQ_IN bit passes through a 2-flop synchronizer, followed by a third "previous" flop; a rising edge is sync2=1 and prev=0.
REQ-015 A detected edge sets the matching pending bit regardless of the mask state; a pending bit clears only on an acknowledge write.
REQ-016 Latency: with IRQ_IN[n] rising before CLK edge k, pending[n] is 1 after edge k+2, and INTR is 1 after edge k+3 when the FSM is IDLE and mask[n]=1.
REQ-017 Mask write: IO_STRB=1 and PORT_ID=MASK_ID loads OUT_PORT into the mask; 1 means enabled.
REQ-018 Acknowledge write: IO_STRB=1 and PORT_ID=ACK_ID clears each pending bit whose OUT_PORT bit is 1.
REQ-019 If an edge sets a bit in the same cycle that an acknowledge write clears it, the set wins and the bit stays 1.
REQ-020 RD_DATA is the mask when PORT_ID=MASK_ID, pending when PORT_ID=STATUS_ID, and 8'h00 otherwise.
REQ-021 FSM state IDLE: INTR=0; when (pending & mask) != 0, the FSM goes to ASSERT and loads the pulse counter with INTR_PULSE.
REQ-022 FSM state ASSERT: INTR=1 and the counter decrements each cycle; at count 1 the FSM goes to WAIT_ACK, so INTR is high for exactly INTR_PULSE cycles.
REQ-023 FSM state WAIT_ACK: INTR=0; any acknowledge write, including data 8'h00, returns the FSM to IDLE on the next edge.
REQ-024 After the return to IDLE, any remaining (pending & mask) bits start a new ASSERT on the following edge, so there is at least one IDLE cycle between pulses.
REQ-025 Acknowledge writes in IDLE or ASSERT clear bits only; they do not change state or truncate the pulse.
REQ-026 Mask changes during ASSERT or WAIT_ACK do not alter the current sequence.
REQ-027 New edges during ASSERT or WAIT_ACK are recorded in pending and serviced per REQ-024.

Reset
REQ-028 When RESET=1, asynchronously: synchronizer and prev flops=0, pending=8'h00, mask=8'h00, counter=0, FSM=IDLE, INTR=0.
REQ-029 An IRQ_IN bit held high through reset release is detected as one rising edge, 2 CLK edges after release.
REQ-030 RESET asserted during ASSERT drops INTR to 0 immediately, without waiting for a clock edge.

Verification
REQ-031 After reset, write 8'h01 to MASK_ID and raise IRQ_IN[0] -> pending=8'h01 after 3 edges, INTR high for exactly 2 cycles, then low; reading STATUS_ID returns 8'h01.
REQ-032 In WAIT_ACK, write 8'h01 to ACK_ID -> pending=8'h00, FSM=IDLE, no further INTR.
REQ-033 Mask=8'h00 and raise IRQ_IN[3] -> pending=8'h08, INTR stays 0; then write mask 8'h08 -> INTR pulse begins 2 edges after the write.
REQ-034 In the same cycle, ACK_ID write of 8'h02 and a new IRQ_IN[1] edge -> pending[1] stays 1; after returning to IDLE, a second INTR pulse follows one IDLE cycle later.
REQ-035 Assert RESET mid-ASSERT -> INTR=0 immediately; pending=8'h00 and mask=8'h00 after reset release.
REQ-036 PORT_ID=8'hFF -> RD_HIT=0 and RD_DATA=8'h00; PORT_ID=8'h20 -> RD_HIT=1 and RD_DATA=mask.
